composite_timing_gen: RTL and testbench

- Parametrised NTSC/PAL-class composite and RGB timing generator; next generation of the fixed 60 Hz composite video timing block.
- Generates half-line based composite sync (hsync, equalization and broad vsync pulses), colour-burst gate, active window, line/frame strobes and gated RGB.
- Supports runtime interlace/progressive selection, latched at frame boundaries; clock-enable pacing; parametrised colour depth.
- Sits between the line buffer/palette and the composite modulator / RGB output pins.

---
 rtl/composite_timing_gen_if.sv | 40 ++++
 rtl/composite_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_composite_timing_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/composite_timing_gen_if.sv
// Port bundle for the composite/RGB timing generator.
//
// Pacing contract: there is no valid/ready pair on this block. clk_en is a
// one-clock qualifier owned by the pixel-rate source and is never
// back-pressured. Registered outputs change only on clocks where clk_en is
// high. The strobes (next_frame, next_line, vblank_pulse) are high for exactly
// one clock, and only after a clock on which clk_en was high.
interface composite_timing_gen_if #(
  parameter int CBITS = 4
);
  // timing source / palette side
  logic                 clk_en;
  logic                 interlace;
  logic [3*CBITS-1:0]   rgb_in;
  // modulator / pin side
  logic                 next_frame;
  logic                 next_line;
  logic                 next_pixel;
  logic                 vblank_pulse;
  logic                 current_field;
  logic                 mode_active;
  logic [3*CBITS-1:0]   rgb_out;
  logic                 active;
  logic                 burst;
  logic                 sync_n;
  logic                 hsync_n;
  logic                 vsync_n;

  modport master (
    output clk_en, interlace, rgb_in,
    input  next_frame, next_line, next_pixel, vblank_pulse, current_field,
           mode_active, rgb_out, active, burst, sync_n, hsync_n, vsync_n
  );

  modport slave (
    input  clk_en, interlace, rgb_in,
    output next_frame, next_line, next_pixel, vblank_pulse, current_field,
           mode_active, rgb_out, active, burst, sync_n, hsync_n, vsync_n
  );
endinterface

// File: rtl/composite_timing_gen.sv
// Half-line based composite sync and RGB timing generator.
// The horizontal counter runs over a full line. The vertical counter counts
// field half-lines, so that the equalization and broad pulses and the odd
// half-line interlace offset fall out of one counter. Every output is
// registered from the counter state seen on the clock that produces it.
module composite_timing_gen #(
  parameter int H_SYNC        = 118,
  parameter int H_BACK_PORCH  = 118,
  parameter int H_ACTIVE      = 1280,
  parameter int H_FRONT_PORCH = 72,
  parameter int H_VSYNC_LEN   = 678,
  parameter int H_EQ_LEN      = 58,
  parameter int BURST_START   = 132,
  parameter int BURST_END     = 196,
  parameter int FIELD_HL      = 525,
  parameter int V_EQ_HL       = 6,
  parameter int V_SYNC_HL     = 6,
  parameter int V_BURST_START = 22,
  parameter int V_ACT_START   = 42,
  parameter int V_ACT_HL      = 480,
  parameter int CBITS         = 4
) (
  input logic                   clk,
  input logic                   rst,
  composite_timing_gen_if.slave bus
);

  localparam int H_TOTAL     = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
  localparam int H_HALF      = H_TOTAL / 2;
  localparam int H_ACT_START = H_SYNC + H_BACK_PORCH;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_EQ2_START = V_EQ_HL + V_SYNC_HL;
  localparam int V_EQ2_END   = 2 * V_EQ_HL + V_SYNC_HL;
  localparam int V_ACT_END   = V_ACT_START + V_ACT_HL;
  localparam int HW          = $clog2(H_TOTAL);
  // Progressive fields are one half-line longer, so vhl must be able to hold FIELD_HL.
  localparam int VW          = $clog2(FIELD_HL + 1);
  localparam int RGB_W       = 3 * CBITS;

  // counter state
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vhl;
  logic          field;
  logic          mode;        // 1 = interlaced, 0 = progressive
  logic          mode_pend;   // capture interlace on the first tick after reset
  logic          frame_pend;  // next next_line also carries next_frame

  // decode of the current state
  logic             h_end;
  logic             hl_tick;
  logic [VW-1:0]    fl_last;
  logic             field_end;
  logic [VW-1:0]    vhl_nxt;
  logic [HW-1:0]    p;
  logic             h_sync;
  logic             h_act;
  logic             h_burst;
  logic             eq;
  logic             vs;
  logic             v_act;
  logic             v_burst;
  logic             c_sync;
  logic             nl_d;
  logic [RGB_W-1:0] rgb_gated;

  // Decode the current counter state into horizontal, vertical and sync terms.
  always_comb begin
    h_end     = (hcnt == HW'(H_TOTAL - 1));
    hl_tick   = bus.clk_en && (h_end || (hcnt == HW'(H_HALF - 1)));
    fl_last   = mode ? VW'(FIELD_HL - 1) : VW'(FIELD_HL);
    field_end = (vhl == fl_last);
    vhl_nxt   = field_end ? '0 : vhl + VW'(1);

    p         = (hcnt >= HW'(H_HALF)) ? hcnt - HW'(H_HALF) : hcnt;
    h_sync    = (hcnt < HW'(H_SYNC));
    h_act     = (hcnt >= HW'(H_ACT_START)) && (hcnt < HW'(H_ACT_END));
    h_burst   = (hcnt >= HW'(BURST_START)) && (hcnt < HW'(BURST_END));

    eq        = (vhl < VW'(V_EQ_HL)) ||
                ((vhl >= VW'(V_EQ2_START)) && (vhl < VW'(V_EQ2_END)));
    vs        = (vhl >= VW'(V_EQ_HL)) && (vhl < VW'(V_EQ2_START));
    v_act     = (vhl >= VW'(V_ACT_START)) && (vhl < VW'(V_ACT_END));
    v_burst   = (vhl >= VW'(V_BURST_START)) && (vhl < VW'(V_ACT_END));

    // Broad pulses take priority over equalization, and both replace hsync.
    if (vs) begin
      c_sync = (p < HW'(H_VSYNC_LEN));
    end else if (eq) begin
      c_sync = (p < HW'(H_EQ_LEN));
    end else begin
      c_sync = h_sync;
    end

    // next_line fires on every line, one tick ahead of the first active pixel.
    nl_d      = (hcnt == HW'(H_ACT_START - 1));
    rgb_gated = (h_act && v_act) ? bus.rgb_in : '0;
  end

  // Advance the line/half-line/field counters and the applied scan mode on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      vhl        <= '0;
      field      <= 1'b0;
      mode       <= 1'b1;
      mode_pend  <= 1'b1;
      frame_pend <= 1'b0;
    end else if (bus.clk_en) begin
      hcnt <= h_end ? '0 : hcnt + HW'(1);
      if (mode_pend) begin
        mode      <= bus.interlace;
        mode_pend <= 1'b0;
      end
      // The pending flag is consumed by the next next_line, which becomes next_frame.
      if (nl_d && frame_pend) begin
        frame_pend <= 1'b0;
      end
      if (hl_tick) begin
        vhl <= vhl_nxt;
        if (field_end) begin
          field <= ~field;
          // The scan mode changes only at a frame boundary (end of field 1).
          if (field) begin
            mode <= bus.interlace;
          end
        end
        if (vhl_nxt == VW'(V_ACT_START - 1)) begin
          frame_pend <= 1'b1;
        end
      end
    end
  end

  // Register the outputs: levels update on ticks only, strobes last one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.next_frame    <= 1'b0;
      bus.next_line     <= 1'b0;
      bus.vblank_pulse  <= 1'b0;
      bus.next_pixel    <= 1'b0;
      bus.current_field <= 1'b0;
      bus.mode_active   <= 1'b1;
      bus.rgb_out       <= '0;
      bus.active        <= 1'b0;
      bus.burst         <= 1'b0;
      bus.sync_n        <= 1'b1;
      bus.hsync_n       <= 1'b1;
      bus.vsync_n       <= 1'b1;
    end else begin
      bus.next_line    <= bus.clk_en && nl_d;
      bus.next_frame   <= bus.clk_en && nl_d && frame_pend;
      bus.vblank_pulse <= hl_tick && field_end;
      if (bus.clk_en) begin
        bus.next_pixel  <= h_act;
        bus.active      <= h_act && v_act;
        bus.burst       <= h_burst && v_burst;
        bus.sync_n      <= ~c_sync;
        bus.hsync_n     <= ~h_sync;
        bus.vsync_n     <= ~vs;
        bus.rgb_out     <= rgb_gated;
        bus.mode_active <= mode;
        if (nl_d && frame_pend) begin
          bus.current_field <= field;
        end
      end
    end
  end

endmodule

// File: tb/tb_composite_timing_gen.sv
// Directed bench for composite_timing_gen using a shrunken timing set:
// 24-tick lines (sync 4, back porch 4, active 12, front porch 4, half 12),
// 15/16 half-line fields, eq half-lines 0-1 and 4-5, broad half-lines 2-3,
// burst from half-line 7, active half-lines 8-13, burst ticks 5-6.
// Window indices below are 1-based clock numbers inside each run_window call.
module tb_composite_timing_gen;
  localparam int CBITS = 4;
  localparam int RW    = 3 * CBITS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  composite_timing_gen_if #(.CBITS(CBITS)) bus ();

  composite_timing_gen #(
    .H_SYNC(4), .H_BACK_PORCH(4), .H_ACTIVE(12), .H_FRONT_PORCH(4),
    .H_VSYNC_LEN(9), .H_EQ_LEN(2), .BURST_START(5), .BURST_END(7),
    .FIELD_HL(15), .V_EQ_HL(2), .V_SYNC_HL(2), .V_BURST_START(7),
    .V_ACT_START(8), .V_ACT_HL(6), .CBITS(CBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // per-window observations
  int c_hs, f_hs, c_sync, c_vs, f_vs, c_nl, f_nl, c_nf, f_nf;
  int c_np, f_np, c_act, c_bst, c_vb, f_vb, bad_rgb, unstable;
  logic first_mode;
  logic [RW-1:0] rgb_exp;

  // Run n clocks; clk_en is high on clocks 1, 1+div, 1+2*div, ...
  task automatic run_window(input int n, input int div);
    logic [RW+7:0] prev;
    logic [RW+7:0] cur;
    c_hs = 0; f_hs = 0; c_sync = 0; c_vs = 0; f_vs = 0; c_nl = 0; f_nl = 0;
    c_nf = 0; f_nf = 0; c_np = 0; f_np = 0; c_act = 0; c_bst = 0; c_vb = 0;
    f_vb = 0; bad_rgb = 0; unstable = 0; first_mode = 1'bx;
    prev = '0;
    for (int i = 1; i <= n; i++) begin
      bus.clk_en = (div <= 1) || (((i - 1) % div) == 0);
      @(posedge clk);
      #1;
      cur = {bus.active, bus.burst, bus.sync_n, bus.hsync_n, bus.vsync_n,
             bus.next_pixel, bus.mode_active, bus.current_field, bus.rgb_out};
      if (i > 1 && !bus.clk_en && cur !== prev) unstable++;
      prev = cur;
      if (i == 1) first_mode = bus.mode_active;
      if (!bus.hsync_n) begin c_hs++; if (f_hs == 0) f_hs = i; end
      if (!bus.sync_n) c_sync++;
      if (!bus.vsync_n) begin c_vs++; if (f_vs == 0) f_vs = i; end
      if (bus.next_line) begin c_nl++; if (f_nl == 0) f_nl = i; end
      if (bus.next_frame) begin c_nf++; if (f_nf == 0) f_nf = i; end
      if (bus.next_pixel) begin c_np++; if (f_np == 0) f_np = i; end
      if (bus.active) c_act++;
      if (bus.burst) c_bst++;
      if (bus.vblank_pulse) begin c_vb++; if (f_vb == 0) f_vb = i; end
      if (bus.active ? (bus.rgb_out !== rgb_exp) : (bus.rgb_out !== '0)) bad_rgb++;
    end
    bus.clk_en = 1'b1;
  endtask

  // Reset asserted mid-line forces every output to its idle value.
  task automatic test_reset();
    bus.clk_en = 1'b1; bus.interlace = 1'b1; bus.rgb_in = 12'hFFF; rgb_exp = 12'hFFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    n_cmp++; if (bus.next_pixel !== 1'b1) begin n_bad++; $display("FAIL pre_reset_next_pixel: got %b want 1", bus.next_pixel); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.sync_n !== 1'b1) begin n_bad++; $display("FAIL rst_sync_n: got %b want 1", bus.sync_n); end
    n_cmp++; if (bus.hsync_n !== 1'b1) begin n_bad++; $display("FAIL rst_hsync_n: got %b want 1", bus.hsync_n); end
    n_cmp++; if (bus.vsync_n !== 1'b1) begin n_bad++; $display("FAIL rst_vsync_n: got %b want 1", bus.vsync_n); end
    n_cmp++; if (bus.mode_active !== 1'b1) begin n_bad++; $display("FAIL rst_mode_active: got %b want 1", bus.mode_active); end
    n_cmp++; if (bus.next_pixel !== 1'b0) begin n_bad++; $display("FAIL rst_next_pixel: got %b want 0", bus.next_pixel); end
    n_cmp++; if (bus.rgb_out !== 12'h000) begin n_bad++; $display("FAIL rst_rgb_out: got %h want 000", bus.rgb_out); end
    n_cmp++; if ({bus.active, bus.burst, bus.next_line, bus.next_frame, bus.vblank_pulse, bus.current_field} !== 6'b0)
      begin n_bad++; $display("FAIL rst_flags: got %b want 000000", {bus.active, bus.burst, bus.next_line, bus.next_frame, bus.vblank_pulse, bus.current_field}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // First line after release: field half-lines 0/1 (equalization).
  task automatic test_first_line();
    run_window(24, 1);
    n_cmp++; if (f_hs !== 1) begin n_bad++; $display("FAIL a_hsync_start: got %0d want 1", f_hs); end
    n_cmp++; if (c_hs !== 4) begin n_bad++; $display("FAIL a_hsync_len: got %0d want 4", c_hs); end
    n_cmp++; if (f_nl !== 8) begin n_bad++; $display("FAIL a_next_line_at: got %0d want 8", f_nl); end
    n_cmp++; if (c_nl !== 1) begin n_bad++; $display("FAIL a_next_line_cnt: got %0d want 1", c_nl); end
    n_cmp++; if (f_np !== 9) begin n_bad++; $display("FAIL a_next_pixel_start: got %0d want 9", f_np); end
    n_cmp++; if (c_np !== 12) begin n_bad++; $display("FAIL a_next_pixel_len: got %0d want 12", c_np); end
    n_cmp++; if (c_sync !== 4) begin n_bad++; $display("FAIL a_eq_sync_lo: got %0d want 4", c_sync); end
    n_cmp++; if (c_vs !== 0) begin n_bad++; $display("FAIL a_vsync_lo: got %0d want 0", c_vs); end
    n_cmp++; if (c_act !== 0) begin n_bad++; $display("FAIL a_active: got %0d want 0", c_act); end
    n_cmp++; if (bad_rgb !== 0) begin n_bad++; $display("FAIL a_rgb_gate: got %0d bad want 0", bad_rgb); end
  endtask

  // Broad-pulse half-lines 2 and 3, then equalization half-lines 4 and 5.
  task automatic test_vsync_eq();
    run_window(12, 1);
    n_cmp++; if (c_sync !== 9) begin n_bad++; $display("FAIL b1_broad_lo: got %0d want 9", c_sync); end
    n_cmp++; if (c_vs !== 12) begin n_bad++; $display("FAIL b1_vsync_lo: got %0d want 12", c_vs); end
    run_window(12, 1);
    n_cmp++; if (c_sync !== 9) begin n_bad++; $display("FAIL b2_broad_lo: got %0d want 9", c_sync); end
    n_cmp++; if (c_vs !== 12) begin n_bad++; $display("FAIL b2_vsync_lo: got %0d want 12", c_vs); end
    run_window(24, 1);
    n_cmp++; if (c_sync !== 4) begin n_bad++; $display("FAIL c_eq_sync_lo: got %0d want 4", c_sync); end
    n_cmp++; if (c_vs !== 0) begin n_bad++; $display("FAIL c_vsync_lo: got %0d want 0", c_vs); end
  endtask

  // Remainder of interlaced field 0; interlace is dropped mid-frame.
  task automatic test_interlace_field0();
    bus.rgb_in = 12'hA5C; rgb_exp = 12'hA5C;
    bus.interlace = 1'b0;
    run_window(108, 1);
    n_cmp++; if (c_nf !== 1 || f_nf !== 32) begin n_bad++; $display("FAIL d_next_frame: got cnt %0d at %0d want 1 at 32", c_nf, f_nf); end
    n_cmp++; if (c_nl !== 5 || f_nl !== 8) begin n_bad++; $display("FAIL d_next_line: got cnt %0d at %0d want 5 at 8", c_nl, f_nl); end
    n_cmp++; if (c_act !== 36) begin n_bad++; $display("FAIL d_active: got %0d want 36", c_act); end
    n_cmp++; if (c_bst !== 6) begin n_bad++; $display("FAIL d_burst: got %0d want 6", c_bst); end
    n_cmp++; if (c_vb !== 1 || f_vb !== 108) begin n_bad++; $display("FAIL d_vblank: got cnt %0d at %0d want 1 at 108", c_vb, f_vb); end
    n_cmp++; if (bad_rgb !== 0) begin n_bad++; $display("FAIL d_rgb_gate: got %0d bad want 0", bad_rgb); end
    n_cmp++; if (bus.current_field !== 1'b0) begin n_bad++; $display("FAIL d_current_field: got %b want 0", bus.current_field); end
    n_cmp++; if (bus.mode_active !== 1'b1) begin n_bad++; $display("FAIL d_mode_active: got %b want 1", bus.mode_active); end
  endtask

  // Interlaced field 1 starts mid-line and is still 15 half-lines long.
  task automatic test_interlace_field1();
    bus.rgb_in = 12'hFFF; rgb_exp = 12'hFFF;
    run_window(180, 1);
    n_cmp++; if (f_hs !== 13) begin n_bad++; $display("FAIL e_hsync_first: got %0d want 13", f_hs); end
    n_cmp++; if (c_nf !== 1 || f_nf !== 92) begin n_bad++; $display("FAIL e_next_frame: got cnt %0d at %0d want 1 at 92", c_nf, f_nf); end
    n_cmp++; if (c_nl !== 7) begin n_bad++; $display("FAIL e_next_line_cnt: got %0d want 7", c_nl); end
    n_cmp++; if (c_act !== 36) begin n_bad++; $display("FAIL e_active: got %0d want 36", c_act); end
    n_cmp++; if (c_bst !== 8) begin n_bad++; $display("FAIL e_burst: got %0d want 8", c_bst); end
    n_cmp++; if (c_vs !== 24 || f_vs !== 25) begin n_bad++; $display("FAIL e_vsync: got cnt %0d at %0d want 24 at 25", c_vs, f_vs); end
    n_cmp++; if (c_vb !== 1 || f_vb !== 180) begin n_bad++; $display("FAIL e_vblank: got cnt %0d at %0d want 1 at 180", c_vb, f_vb); end
    n_cmp++; if (bus.current_field !== 1'b1) begin n_bad++; $display("FAIL e_current_field: got %b want 1", bus.current_field); end
    n_cmp++; if (bus.mode_active !== 1'b1) begin n_bad++; $display("FAIL e_mode_active: got %b want 1", bus.mode_active); end
  endtask

  // Progressive frame: both fields are 16 half-lines and start at tick 0 of a line.
  task automatic test_progressive();
    run_window(192, 1);
    n_cmp++; if (first_mode !== 1'b0) begin n_bad++; $display("FAIL f_mode_switch: got %b want 0", first_mode); end
    n_cmp++; if (f_hs !== 1) begin n_bad++; $display("FAIL f_hsync_first: got %0d want 1", f_hs); end
    n_cmp++; if (c_nf !== 1 || f_nf !== 104) begin n_bad++; $display("FAIL f_next_frame: got cnt %0d at %0d want 1 at 104", c_nf, f_nf); end
    n_cmp++; if (c_nl !== 8) begin n_bad++; $display("FAIL f_next_line_cnt: got %0d want 8", c_nl); end
    n_cmp++; if (c_act !== 36 || c_bst !== 6) begin n_bad++; $display("FAIL f_act_burst: got %0d/%0d want 36/6", c_act, c_bst); end
    n_cmp++; if (c_vb !== 1 || f_vb !== 192) begin n_bad++; $display("FAIL f_vblank: got cnt %0d at %0d want 1 at 192", c_vb, f_vb); end
    n_cmp++; if (bus.current_field !== 1'b0) begin n_bad++; $display("FAIL f_current_field: got %b want 0", bus.current_field); end
    run_window(192, 1);
    n_cmp++; if (f_hs !== 1) begin n_bad++; $display("FAIL g_hsync_first: got %0d want 1", f_hs); end
    n_cmp++; if (c_nf !== 1 || f_nf !== 104) begin n_bad++; $display("FAIL g_next_frame: got cnt %0d at %0d want 1 at 104", c_nf, f_nf); end
    n_cmp++; if (c_vb !== 1 || f_vb !== 192) begin n_bad++; $display("FAIL g_vblank: got cnt %0d at %0d want 1 at 192", c_vb, f_vb); end
    n_cmp++; if (bus.current_field !== 1'b1) begin n_bad++; $display("FAIL g_current_field: got %b want 1", bus.current_field); end
  endtask

  // clk_en one clock in four: levels stretch x4, strobes stay one clock wide.
  task automatic test_clk_en_div();
    run_window(768, 4);
    n_cmp++; if (f_hs !== 1) begin n_bad++; $display("FAIL h_hsync_first: got %0d want 1", f_hs); end
    n_cmp++; if (c_vs !== 96) begin n_bad++; $display("FAIL h_vsync_lo: got %0d want 96", c_vs); end
    n_cmp++; if (c_act !== 144) begin n_bad++; $display("FAIL h_active: got %0d want 144", c_act); end
    n_cmp++; if (c_bst !== 24) begin n_bad++; $display("FAIL h_burst: got %0d want 24", c_bst); end
    n_cmp++; if (c_nl !== 8) begin n_bad++; $display("FAIL h_next_line_cnt: got %0d want 8", c_nl); end
    n_cmp++; if (c_nf !== 1 || f_nf !== 413) begin n_bad++; $display("FAIL h_next_frame: got cnt %0d at %0d want 1 at 413", c_nf, f_nf); end
    n_cmp++; if (c_vb !== 1 || f_vb !== 765) begin n_bad++; $display("FAIL h_vblank: got cnt %0d at %0d want 1 at 765", c_vb, f_vb); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL h_hold_between_ticks: got %0d changes want 0", unstable); end
    n_cmp++; if (bad_rgb !== 0) begin n_bad++; $display("FAIL h_rgb_gate: got %0d bad want 0", bad_rgb); end
    n_cmp++; if (bus.current_field !== 1'b0) begin n_bad++; $display("FAIL h_current_field: got %b want 0", bus.current_field); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_first_line();
    test_vsync_eq();
    test_interlace_field0();
    test_interlace_field1();
    test_progressive();
    test_clk_en_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
